// File: rtl/esdi_pkg.sv
// Shared definitions for the ESDI drive-side serial command responder.
package esdi_pkg;

    localparam logic [3:0] OP_REQ_STATUS = 4'd2;
    localparam logic [3:0] OP_REQ_CONFIG = 4'd3;
    localparam int         WORD_BITS     = 17;

    typedef enum logic [2:0] {
        S_WREQ,
        S_SETUP,
        S_WREL,
        S_HOLD,
        S_RESP
    } state_t;

    typedef enum logic {
        PH_RX,
        PH_TX
    } phase_t;

    function automatic logic is_query(input logic [15:0] word);
        return (word[15:12] == OP_REQ_STATUS) || (word[15:12] == OP_REQ_CONFIG);
    endfunction

endpackage

// File: rtl/esdi_sync2.sv
// Two-flop synchroniser for asynchronous ESDI wire inputs; idles high like the bus.
module esdi_sync2 (
    input  logic csr_aclk,
    input  logic csr_aresetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
        if (!csr_aresetn) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/esdi_drive_cmd_responder.sv
// Drive-side ESDI serial command responder: receives 17-bit host commands and
// serialises firmware-supplied status/config replies, all on a req/ack bit handshake.
module esdi_drive_cmd_responder
    import esdi_pkg::*;
#(
    parameter int DATA_SETUP  = 6,
    parameter int REL_DELAY   = 6,
    parameter int BIT_TIMEOUT = 1_000_000
) (
    input  logic        csr_aclk,
    input  logic        csr_aresetn,
    input  logic        esdi_transfer_req,
    input  logic        esdi_command_data,
    output logic        esdi_transfer_ack,
    output logic        esdi_confstat_data,
    output logic        esdi_command_complete,
    output logic        esdi_attention,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [15:0] cmd_data,
    output logic        cmd_parity_err,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic [15:0] resp_data,
    input  logic        cmd_done,
    input  logic        attn_req,
    output logic        err_timeout,
    output logic        err_overrun
);

    localparam int CNT_MAX = (BIT_TIMEOUT > DATA_SETUP)
                           ? ((BIT_TIMEOUT > REL_DELAY) ? BIT_TIMEOUT : REL_DELAY)
                           : ((DATA_SETUP > REL_DELAY) ? DATA_SETUP : REL_DELAY);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DATA_SETUP - 1);
    localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(REL_DELAY - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(BIT_TIMEOUT - 1);
    localparam logic [4:0]       LAST_BIT   = 5'(WORD_BITS);

    state_t           state;
    phase_t           phase;
    logic [CNT_W-1:0] cyc_cnt;
    logic [4:0]       bit_cnt;
    logic [16:0]      rx_shift;
    logic [16:0]      tx_shift;
    logic             req_s;
    logic             cmd_s;
    logic             rx_perr;
    logic             timeout_hit;

    esdi_sync2 u_sync_req (
        .csr_aclk    (csr_aclk),
        .csr_aresetn (csr_aresetn),
        .d           (esdi_transfer_req),
        .q           (req_s)
    );

    esdi_sync2 u_sync_cmd (
        .csr_aclk    (csr_aclk),
        .csr_aresetn (csr_aresetn),
        .d           (esdi_command_data),
        .q           (cmd_s)
    );

    assign rx_perr = ~^rx_shift;

    // Only a host stalled mid-word or a firmware that never replies can time out.
    always_comb begin
        timeout_hit = 1'b0;
        if (cyc_cnt == TMO_LAST) begin
            case (state)
                S_WREQ:  timeout_hit = (bit_cnt != '0) && (bit_cnt != LAST_BIT) && req_s;
                S_WREL:  timeout_hit = !req_s;
                S_RESP:  timeout_hit = !resp_valid;
                default: timeout_hit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
        if (!csr_aresetn) begin
            state                 <= S_WREQ;
            phase                 <= PH_RX;
            cyc_cnt               <= '0;
            bit_cnt               <= '0;
            rx_shift              <= '0;
            tx_shift              <= '0;
            esdi_transfer_ack     <= 1'b1;
            esdi_confstat_data    <= 1'b1;
            esdi_command_complete <= 1'b0;
            cmd_valid             <= 1'b0;
            cmd_data              <= '0;
            cmd_parity_err        <= 1'b0;
            resp_ready            <= 1'b0;
            err_timeout           <= 1'b0;
            err_overrun           <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            cyc_cnt     <= cyc_cnt + CNT_W'(1);
            if (cmd_valid && cmd_ready)
                cmd_valid <= 1'b0;
            if (cmd_done && esdi_command_complete)
                esdi_command_complete <= 1'b0;

            if (timeout_hit) begin
                state              <= S_WREQ;
                phase              <= PH_RX;
                bit_cnt            <= '0;
                cyc_cnt            <= '0;
                esdi_transfer_ack  <= 1'b1;
                esdi_confstat_data <= 1'b1;
                resp_ready         <= 1'b0;
                err_timeout        <= 1'b1;
            end else begin
                case (state)
                    S_WREQ: begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            cyc_cnt <= '0;
                            if (phase == PH_TX) begin
                                esdi_confstat_data    <= 1'b1;
                                esdi_command_complete <= 1'b0;
                                phase                 <= PH_RX;
                            end else if (cmd_valid && !cmd_ready) begin
                                err_overrun <= 1'b1;
                            end else begin
                                cmd_valid      <= 1'b1;
                                cmd_data       <= rx_shift[16:1];
                                cmd_parity_err <= rx_perr;
                                if (is_query(rx_shift[16:1]) && !rx_perr) begin
                                    state      <= S_RESP;
                                    resp_ready <= 1'b1;
                                end
                            end
                        end else if (!req_s) begin
                            state   <= S_SETUP;
                            cyc_cnt <= '0;
                            if (phase == PH_TX) begin
                                esdi_confstat_data <= ~tx_shift[16];
                                tx_shift           <= {tx_shift[15:0], 1'b0};
                            end else begin
                                // Command data is active-low on the wire.
                                rx_shift <= {rx_shift[15:0], ~cmd_s};
                                if (bit_cnt == '0)
                                    esdi_command_complete <= 1'b1;
                            end
                        end else if (bit_cnt == '0) begin
                            cyc_cnt <= '0;
                        end
                    end
                    S_SETUP: begin
                        if (cyc_cnt == SETUP_LAST) begin
                            esdi_transfer_ack <= 1'b0;
                            state             <= S_WREL;
                            cyc_cnt           <= '0;
                        end
                    end
                    S_WREL: begin
                        if (req_s) begin
                            state   <= S_HOLD;
                            cyc_cnt <= '0;
                        end
                    end
                    S_HOLD: begin
                        if (cyc_cnt == REL_LAST) begin
                            esdi_transfer_ack <= 1'b1;
                            bit_cnt           <= bit_cnt + 5'd1;
                            state             <= S_WREQ;
                            cyc_cnt           <= '0;
                        end
                    end
                    S_RESP: begin
                        if (resp_valid) begin
                            tx_shift   <= {resp_data, ~^resp_data};
                            phase      <= PH_TX;
                            resp_ready <= 1'b0;
                            state      <= S_WREQ;
                            cyc_cnt    <= '0;
                        end
                    end
                    default: begin
                        state   <= S_WREQ;
                        cyc_cnt <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
        if (!csr_aresetn)
            esdi_attention <= 1'b1;
        else
            esdi_attention <= ~attn_req;
    end

endmodule

// File: tb/tb_esdi_drive_cmd_responder.sv
// Self-checking bench: a host model drives the ESDI wires; a word-level model predicts results.
module tb_esdi_drive_cmd_responder;

    localparam int DS        = 6;
    localparam int REL       = 6;
    localparam int BT        = 300;
    localparam int ACK_BOUND = 100;
    localparam int NVEC      = 9;

    logic        clk;
    logic        rst_n;
    logic        req_w;
    logic        cmd_w;
    logic        ack;
    logic        confstat;
    logic        cc;
    logic        attention;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic        cmd_perr;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic        cmd_done;
    logic        attn_req;
    logic        err_timeout;
    logic        err_overrun;

    int checks   = 0;
    int failures = 0;
    int tmo_seen = 0;
    int ovr_seen = 0;

    typedef struct {
        logic [15:0] data;
        bit          flip;
        logic [15:0] resp;
        logic [15:0] exp_data;
        bit          exp_perr;
        bit          exp_query;
    } vec_t;

    vec_t vecs [NVEC];

    esdi_drive_cmd_responder #(
        .DATA_SETUP  (DS),
        .REL_DELAY   (REL),
        .BIT_TIMEOUT (BT)
    ) dut (
        .csr_aclk              (clk),
        .csr_aresetn           (rst_n),
        .esdi_transfer_req     (req_w),
        .esdi_command_data     (cmd_w),
        .esdi_transfer_ack     (ack),
        .esdi_confstat_data    (confstat),
        .esdi_command_complete (cc),
        .esdi_attention        (attention),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_data              (cmd_data),
        .cmd_parity_err        (cmd_perr),
        .resp_valid            (resp_valid),
        .resp_ready            (resp_ready),
        .resp_data             (resp_data),
        .cmd_done              (cmd_done),
        .attn_req              (attn_req),
        .err_timeout           (err_timeout),
        .err_overrun           (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_timeout === 1'b1) tmo_seen++;
        if (err_overrun === 1'b1) ovr_seen++;
    end

    // Word-level model: odd parity over 17 bits, queries are opcodes 2 and 3.
    function automatic bit modelParityBit(input logic [15:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    function automatic bit modelParityErr(input logic [15:0] d, input bit flip);
        int ones;
        ones = $countones(d) + int'(modelParityBit(d) ^ flip);
        return (ones % 2) == 0;
    endfunction

    function automatic bit modelQuery(input logic [15:0] d, input bit flip);
        int opcode;
        opcode = int'(d) / 4096;
        return (opcode == 2 || opcode == 3) && !modelParityErr(d, flip);
    endfunction

    function automatic logic [16:0] modelReply(input logic [15:0] r);
        return {r, modelParityBit(r)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic boundFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=wait-bound-expired expected=event", name);
    endtask

    task automatic waitAck(input logic level, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < ACK_BOUND; i++) begin
            @(negedge clk);
            cycles++;
            if (ack === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic hostBit(input logic wbit, output logic rbit, output int lat);
        int c;
        bit ok;
        cmd_w = ~wbit;
        req_w = 1'b0;
        waitAck(1'b0, c, ok);
        lat = c;
        if (!ok) boundFail("ack_fall");
        rbit  = ~confstat;
        req_w = 1'b1;
        cmd_w = 1'b1;
        waitAck(1'b1, c, ok);
        if (!ok) boundFail("ack_rise");
    endtask

    task automatic hostSendWord(input logic [15:0] d, input bit flip, input int nbits);
        logic [16:0] bits;
        logic        rb;
        int          lat;
        bits = {d, modelParityBit(d) ^ flip};
        for (int i = 16; i > 16 - nbits; i--) begin
            hostBit(bits[i], rb, lat);
            if (i == 16) checkOutput("rx_ack_latency", lat, DS + 3);
        end
    endtask

    task automatic hostReadWord(output logic [16:0] w);
        logic rb;
        int   lat;
        w = '0;
        for (int i = 16; i >= 0; i--) begin
            hostBit(1'b0, rb, lat);
            w[i] = rb;
            if (i == 16) checkOutput("tx_ack_latency", lat, DS + 3);
        end
    endtask

    task automatic waitCmdValid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic consumeCmd();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        checkOutput("cmd_valid_cleared", cmd_valid, 1'b0);
    endtask

    task automatic applyStimulus(input vec_t v);
        bit          ok;
        logic [16:0] got;
        hostSendWord(v.data, v.flip, 17);
        waitCmdValid(ok);
        if (!ok) begin
            boundFail("cmd_valid_wait");
            return;
        end
        checkOutput("cmd_data", cmd_data, v.exp_data);
        checkOutput("cmd_parity_err", cmd_perr, v.exp_perr);
        checkOutput("cc_busy", cc, 1'b1);
        @(negedge clk);
        checkOutput("resp_ready", resp_ready, v.exp_query);
        consumeCmd();
        if (v.exp_query) begin
            resp_data  = v.resp;
            resp_valid = 1'b1;
            @(negedge clk);
            resp_valid = 1'b0;
            checkOutput("resp_ready_drop", resp_ready, 1'b0);
            hostReadWord(got);
            checkOutput("reply_word", got, modelReply(v.resp));
            repeat (3) @(negedge clk);
            checkOutput("cc_after_tx", cc, 1'b0);
            checkOutput("confstat_idle", confstat, 1'b1);
        end else begin
            repeat (3) @(negedge clk);
            checkOutput("cc_before_done", cc, 1'b1);
            cmd_done = 1'b1;
            @(negedge clk);
            cmd_done = 1'b0;
            checkOutput("cc_after_done", cc, 1'b0);
        end
    endtask

    function automatic vec_t makeVec(input logic [15:0] d, input bit flip, input logic [15:0] r);
        vec_t v;
        v.data      = d;
        v.flip      = flip;
        v.resp      = r;
        v.exp_data  = d;
        v.exp_perr  = modelParityErr(d, flip);
        v.exp_query = modelQuery(d, flip);
        return v;
    endfunction

    initial begin
        int          base;
        bit          ok;
        logic [15:0] d;

        rst_n      = 1'b0;
        req_w      = 1'b1;
        cmd_w      = 1'b1;
        cmd_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        cmd_done   = 1'b0;
        attn_req   = 1'b0;

        vecs[0] = makeVec(16'h1234, 1'b0, 16'h0000);
        vecs[1] = makeVec(16'h2000, 1'b0, 16'h00A5);
        vecs[2] = makeVec(16'h3000, 1'b1, 16'h0000);
        for (int i = 3; i < NVEC; i++) begin
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 1) d[15:12] = 4'($urandom_range(2, 3));
            vecs[i] = makeVec(d, $urandom_range(0, 3) == 0, 16'($urandom));
        end

        repeat (3) @(negedge clk);
        checkOutput("rst_ack", ack, 1'b1);
        checkOutput("rst_confstat", confstat, 1'b1);
        checkOutput("rst_cc", cc, 1'b0);
        checkOutput("rst_attention", attention, 1'b1);
        checkOutput("rst_cmd_valid", cmd_valid, 1'b0);
        checkOutput("rst_resp_ready", resp_ready, 1'b0);
        checkOutput("rst_errors", {err_timeout, err_overrun}, 2'b00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i]);

        // Idle with no word in progress must never time out.
        base = tmo_seen;
        repeat (BT + 50) @(negedge clk);
        checkOutput("idle_no_timeout", tmo_seen - base, 0);

        // Host stalls after 5 bits.
        base = tmo_seen;
        hostSendWord(16'h0FFF, 1'b0, 5);
        for (int i = 0; i < BT + 100; i++) begin
            @(negedge clk);
            if (tmo_seen != base) break;
        end
        checkOutput("timeout_pulse", tmo_seen - base, 1);
        checkOutput("timeout_ack", ack, 1'b1);
        applyStimulus(makeVec(16'h0FFF, 1'b0, 16'h0000));

        // Overrun: second word arrives before the first is taken.
        hostSendWord(16'h1234, 1'b0, 17);
        waitCmdValid(ok);
        if (!ok) boundFail("overrun_first_valid");
        base = ovr_seen;
        hostSendWord(16'h5678, 1'b0, 17);
        repeat (3) @(negedge clk);
        checkOutput("overrun_pulse", ovr_seen - base, 1);
        checkOutput("overrun_keep", cmd_data, 16'h1234);
        consumeCmd();
        repeat (3) @(negedge clk);
        checkOutput("overrun_no_second", cmd_valid, 1'b0);
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;

        // Reset during a TX bit with ack asserted.
        hostSendWord(16'h2000, 1'b0, 17);
        waitCmdValid(ok);
        if (!ok) boundFail("reset_query_valid");
        consumeCmd();
        checkOutput("reset_resp_ready", resp_ready, 1'b1);
        resp_data  = 16'hFFFF;
        resp_valid = 1'b1;
        @(negedge clk);
        resp_valid = 1'b0;
        req_w = 1'b0;
        waitAck(1'b0, base, ok);
        if (!ok) boundFail("reset_ack_fall");
        checkOutput("pre_reset_confstat", confstat, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ack", ack, 1'b1);
        checkOutput("async_rst_confstat", confstat, 1'b1);
        checkOutput("async_rst_cc", cc, 1'b0);
        req_w = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        attn_req = 1'b1;
        #1;
        checkOutput("attn_before_edge", attention, 1'b1);
        @(negedge clk);
        checkOutput("attn_asserted", attention, 1'b0);
        attn_req = 1'b0;
        @(negedge clk);
        checkOutput("attn_released", attention, 1'b1);
        applyStimulus(makeVec(16'h1234, 1'b0, 16'h0000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
